// File: rtl/snake_pkg.sv
// +--------------------------------------------------------------------+
// | snake_pkg : shared VGA timing, grid and colour constants           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package snake_pkg;

  localparam int c_CLK_DIV  = 4;
  localparam int c_H_ACTIVE = 640;
  localparam int c_H_FP     = 16;
  localparam int c_H_SYNC   = 96;
  localparam int c_H_BP     = 48;
  localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;
  localparam int c_V_ACTIVE = 480;
  localparam int c_V_FP     = 10;
  localparam int c_V_SYNC   = 2;
  localparam int c_V_BP     = 33;
  localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;
  localparam int c_CELL_PX  = 10;
  localparam int c_PIPE_DLY = 1;
  localparam int c_GRID_W   = 64;
  localparam int c_GRID_H   = 48;

  localparam logic [11:0] c_COLOR_BLACK = 12'h000;
  localparam logic [11:0] c_COLOR_BG    = 12'hFFF;
  localparam logic [11:0] c_COLOR_SNAKE = 12'h0F0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// +--------------------------------------------------------------------+
// | vga_axis_counter : one raster axis with window decode and cell idx |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CELL   = 10,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic             wrap,
  output logic             last_active,
  output logic             active,
  output logic             sync_n,
  output logic [IDX_W-1:0] index
);

  localparam int c_TOTAL = ACTIVE + FP + SYNC + BP;
  localparam int c_CNT_W = $clog2(c_TOTAL);
  localparam int c_SUB_W = (CELL > 1) ? $clog2(CELL) : 1;

  logic [c_CNT_W-1:0] r_cnt;
  logic [c_SUB_W-1:0] r_sub;
  logic [IDX_W-1:0]   r_idx;

  assign wrap        = adv && (r_cnt == c_CNT_W'(c_TOTAL - 1));
  assign last_active = (r_cnt == c_CNT_W'(ACTIVE - 1));
  assign active      = (r_cnt < c_CNT_W'(ACTIVE));
  assign sync_n      = !((r_cnt >= c_CNT_W'(ACTIVE + FP)) &&
                         (r_cnt <  c_CNT_W'(ACTIVE + FP + SYNC)));
  assign index       = r_idx;

  // Clearing on the last active count keeps the index at 0 throughout blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sub <= '0;
      r_idx <= '0;
    end else if (adv) begin
      r_cnt <= wrap ? '0 : r_cnt + 1'b1;
      if (wrap || last_active) begin
        r_sub <= '0;
        r_idx <= '0;
      end else if (active) begin
        if (r_sub == c_SUB_W'(CELL - 1)) begin
          r_sub <= '0;
          r_idx <= r_idx + 1'b1;
        end else begin
          r_sub <= r_sub + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/snake_vga_scan.sv
// +--------------------------------------------------------------------+
// | snake_vga_scan : 640x480 raster timing, cell indices, blanked RGB  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module snake_vga_scan
  import snake_pkg::*;
#(
  parameter int CLK_DIV  = c_CLK_DIV,
  parameter int H_ACTIVE = c_H_ACTIVE,
  parameter int H_FP     = c_H_FP,
  parameter int H_SYNC   = c_H_SYNC,
  parameter int H_BP     = c_H_BP,
  parameter int V_ACTIVE = c_V_ACTIVE,
  parameter int V_FP     = c_V_FP,
  parameter int V_SYNC   = c_V_SYNC,
  parameter int V_BP     = c_V_BP,
  parameter int CELL_PX  = c_CELL_PX,
  parameter int PIPE_DLY = c_PIPE_DLY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] color,
  output logic [5:0]  hIndex,
  output logic [5:0]  vIndex,
  output logic        pix_en,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick
);

  localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [c_DIV_W-1:0]        r_div;
  logic                      w_pix_en;
  logic                      w_h_wrap, w_h_last, w_h_act, w_hs_n;
  logic                      w_v_wrap, w_v_last, w_v_act, w_vs_n;
  logic [2:0]                w_raw;
  logic [2:0]                w_dly;
  logic [PIPE_DLY-1:0][2:0]  r_pipe;
  rgb_t                      r_rgb;
  logic                      r_hs, r_vs, r_tick;

  assign w_pix_en = (r_div == c_DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_div <= '0;
    else        r_div <= w_pix_en ? '0 : r_div + 1'b1;
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .CELL(CELL_PX), .IDX_W(6)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .adv(w_pix_en),
    .wrap(w_h_wrap), .last_active(w_h_last), .active(w_h_act),
    .sync_n(w_hs_n), .index(hIndex)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .CELL(CELL_PX), .IDX_W(6)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .adv(w_h_wrap),
    .wrap(w_v_wrap), .last_active(w_v_last), .active(w_v_act),
    .sync_n(w_vs_n), .index(vIndex)
  );

  // {active, hs_n, vs_n} delayed to line up with the mapper's colour return.
  assign w_raw = {w_h_act & w_v_act, w_hs_n, w_vs_n};
  assign w_dly = r_pipe[PIPE_DLY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= {PIPE_DLY{3'b011}};
      r_rgb  <= '0;
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_h_wrap & w_v_last;
      if (w_pix_en) begin
        r_pipe[0] <= w_raw;
        for (int i = 1; i < PIPE_DLY; i++) r_pipe[i] <= r_pipe[i-1];
        r_rgb <= w_dly[2] ? rgb_t'(color) : rgb_t'(c_COLOR_BLACK);
        r_hs  <= w_dly[1];
        r_vs  <= w_dly[0];
      end
    end
  end

  assign pix_en     = w_pix_en;
  assign vga_r      = r_rgb.r;
  assign vga_g      = r_rgb.g;
  assign vga_b      = r_rgb.b;
  assign hsync      = r_hs;
  assign vsync      = r_vs;
  assign frame_tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_snake_vga_scan.sv
// +--------------------------------------------------------------------+
// | tb_snake_vga_scan : directed checks on a full-size and a small DUT |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_snake_vga_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] color_d;
  logic [11:0] color_s = 12'h000;

  logic [5:0] hidx_d, vidx_d, hidx_s, vidx_s;
  logic       pix_d, pix_s, hs_d, hs_s, vs_d, vs_s, tick_d, tick_s;
  logic [3:0] r_d, g_d, b_d, r_s, g_s, b_s;

  int n_checks = 0;
  int n_errs   = 0;
  int ecnt     = 0;
  int t0       = 0;
  int tcnt_d   = 0;
  int tcnt_s   = 0;
  int tfirst_s = 0;
  int tlast_s  = 0;
  int base_s   = 0;

  always #5 clk = ~clk;

  // Full 640x480 timing instance, fed a constant white colour.
  snake_vga_scan u_dut (
    .clk(clk), .rst_n(rst_n), .color(color_d),
    .hIndex(hidx_d), .vIndex(vidx_d), .pix_en(pix_d),
    .vga_r(r_d), .vga_g(g_d), .vga_b(b_d),
    .hsync(hs_d), .vsync(vs_d), .frame_tick(tick_d)
  );

  // Shrunk raster (56 px x 38 lines) so whole frames fit in a short run.
  snake_vga_scan #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(3)
  ) u_dut_s (
    .clk(clk), .rst_n(rst_n), .color(color_s),
    .hIndex(hidx_s), .vIndex(vidx_s), .pix_en(pix_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
    .hsync(hs_s), .vsync(vs_s), .frame_tick(tick_s)
  );

  // Echo mapper: colour = {hIndex, vIndex}, one pixel of latency.
  always @(posedge clk) if (pix_s) color_s <= {hidx_s, vidx_s};

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(negedge clk) begin
    if (tick_d) tcnt_d <= tcnt_d + 1;
    if (tick_s) begin
      if (tcnt_s == 0) tfirst_s <= ecnt;
      tlast_s <= ecnt;
      tcnt_s  <= tcnt_s + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Park on the falling edge that follows rising edge n after release.
  task automatic at_edge(input int n);
    while ((ecnt - t0) < n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    color_d = 12'hFFF;
    repeat (5) @(negedge clk);
    check("rst_hidx",  32'(hidx_d), 32'd0);
    check("rst_vidx",  32'(vidx_d), 32'd0);
    check("rst_pix",   32'(pix_d),  32'd0);
    check("rst_rgb",   32'({r_d, g_d, b_d}), 32'd0);
    check("rst_hs",    32'(hs_d),   32'd1);
    check("rst_vs",    32'(vs_d),   32'd1);
    check("rst_tick",  32'(tick_d), 32'd0);
    rst_n = 1'b1;
    t0    = ecnt;

    at_edge(2);    check("pix_pre",     32'(pix_d), 32'd0);
    at_edge(3);    check("pix_first",   32'(pix_d), 32'd1);
    at_edge(9);    check("rgb_px0",     32'({r_d, g_d, b_d}), 32'hFFF);
    at_edge(37);   check("hidx_h9",     32'(hidx_d), 32'd0);
                   check("hidx_s_h9",   32'(hidx_s), 32'd0);
    at_edge(41);   check("hidx_h10",    32'(hidx_d), 32'd1);
                   check("hidx_s_h10",  32'(hidx_s), 32'd1);
    at_edge(157);  check("hidx_s_h39",  32'(hidx_s), 32'd3);
    at_edge(161);  check("hidx_s_h40",  32'(hidx_s), 32'd0);
    at_edge(2017); check("vidx_s_l9",   32'(vidx_s), 32'd0);
    at_edge(2241); check("vidx_s_l10",  32'(vidx_s), 32'd1);
    at_edge(2325); check("echo_19_10",  32'({r_s, g_s, b_s}), 32'h041);
    at_edge(2329); check("echo_20_10",  32'({r_s, g_s, b_s}), 32'h081);
    at_edge(2369); check("echo_30_10",  32'({r_s, g_s, b_s}), 32'h0C1);
    at_edge(2409); check("echo_hblank", 32'({r_s, g_s, b_s}), 32'h000);
    at_edge(2557); check("hidx_h639",   32'(hidx_d), 32'd63);
    at_edge(2561); check("hidx_h640",   32'(hidx_d), 32'd0);
    at_edge(2565); check("rgb_px639",   32'({r_d, g_d, b_d}), 32'hFFF);
    at_edge(2569); check("rgb_px640",   32'({r_d, g_d, b_d}), 32'h000);
    at_edge(2631); check("hs_pre_fall", 32'(hs_d), 32'd1);
    at_edge(2632); check("hs_fall",     32'(hs_d), 32'd0);
    at_edge(3015); check("hs_low_end",  32'(hs_d), 32'd0);
    at_edge(3016); check("hs_rise",     32'(hs_d), 32'd1);
    at_edge(3201); check("vidx_l1",     32'(vidx_d), 32'd0);
    at_edge(4381); check("echo_29_19",  32'({r_s, g_s, b_s}), 32'h081);
    at_edge(5831); check("hs_pre_fall2",32'(hs_d), 32'd1);
    at_edge(5832); check("hs_fall2",    32'(hs_d), 32'd0);
    at_edge(6497); check("vidx_s_l29",  32'(vidx_s), 32'd2);
    at_edge(6661); check("echo_39_29",  32'({r_s, g_s, b_s}), 32'h0C2);
    at_edge(6721); check("vidx_s_l30",  32'(vidx_s), 32'd0);
    at_edge(6749); check("echo_vblank", 32'({r_s, g_s, b_s}), 32'h000);
    at_edge(7399); check("vs_pre_fall", 32'(vs_s), 32'd1);
    at_edge(7400); check("vs_fall",     32'(vs_s), 32'd0);
    at_edge(7847); check("vs_low_end",  32'(vs_s), 32'd0);
    at_edge(7848); check("vs_rise",     32'(vs_s), 32'd1);
    at_edge(15911); check("vs_pre_fall2", 32'(vs_s), 32'd1);
    at_edge(15912); check("vs_fall2",     32'(vs_s), 32'd0);
    at_edge(17000);
    check("tick_count",  32'(tcnt_s), 32'd2);
    check("tick_first",  32'(tfirst_s - t0), 32'd6720);
    check("tick_second", 32'(tlast_s - t0), 32'd15232);
    check("tick_full",   32'(tcnt_d), 32'd0);

    // Abort mid-frame while both instances show live pixels.
    at_edge(19823);
    check("pre_rst_rgb_s", 32'({r_s, g_s, b_s}), 32'h081);
    check("pre_rst_idx_s", 32'({hidx_s, vidx_s}), 32'({6'd2, 6'd1}));
    check("pre_rst_rgb",   32'({r_d, g_d, b_d}), 32'hFFF);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pix",   32'(pix_d), 32'd0);
    check("mid_rst_rgb",   32'({r_d, g_d, b_d}), 32'd0);
    check("mid_rst_rgb_s", 32'({r_s, g_s, b_s}), 32'd0);
    check("mid_rst_idx_s", 32'({hidx_s, vidx_s}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    t0     = ecnt;
    base_s = tcnt_s;

    at_edge(3);    check("re_pix_first",  32'(pix_s), 32'd1);
    at_edge(41);   check("re_hidx_s_h10", 32'(hidx_s), 32'd1);
    at_edge(7000);
    check("re_tick_count", 32'(tcnt_s - base_s), 32'd1);
    check("re_tick_time",  32'(tlast_s - t0), 32'd6720);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
